// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, opcode field,
// halt opcode and the fetch state encoding.
package pc_sequencer_pkg;

  localparam int DEF_PC_W  = 8;
  localparam int DEF_INS_W = 32;
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;

  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  function automatic logic [5:0] opcode(input logic [DEF_INS_W-1:0] ins);
    return ins[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/pc_sequencer_if_id_reg.sv
// IF/ID pipeline register: loads {ins, pc, pc+1} on load, drops the valid bit
// on flush (payload is kept), otherwise holds.
module if_id_reg #(
  parameter int PC_W  = 8,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             load,
  input  logic             flush,
  input  logic [INS_W-1:0] ins_nxt,
  input  logic [PC_W-1:0]  pc_nxt,
  input  logic [PC_W-1:0]  pc_plus1_nxt,
  output logic             valid,
  output logic [INS_W-1:0] ins,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1
);

  logic             valid_r;
  logic [INS_W-1:0] ins_r;
  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  pc_plus1_r;

  // Pipeline register with flush taking priority over load.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      valid_r    <= 1'b0;
      ins_r      <= {INS_W{1'b0}};
      pc_r       <= {PC_W{1'b0}};
      pc_plus1_r <= {PC_W{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r    <= 1'b1;
      ins_r      <= ins_nxt;
      pc_r       <= pc_nxt;
      pc_plus1_r <= pc_plus1_nxt;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid    = valid_r;
  assign ins      = ins_r;
  assign pc       = pc_r;
  assign pc_plus1 = pc_plus1_r;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch front end: owns the PC, next-PC selection and the RUN/HALT
// state, and feeds the IF/ID register for decode.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               PC_W    = DEF_PC_W,
  parameter int               INS_W   = DEF_INS_W,
  parameter logic [PC_W-1:0]  RST_PC  = {PC_W{1'b0}},
  parameter logic [5:0]       HALT_OP = OP_HALT
) (
  input  logic             clk,
  input  logic             rstd,
  output logic [PC_W-1:0]  pc_f,
  input  logic [INS_W-1:0] ins_f,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             valid_d,
  output logic [INS_W-1:0] ins_d,
  output logic [PC_W-1:0]  pc_d,
  output logic [PC_W-1:0]  pc_plus1_d,
  output logic             halted
);

  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  pc_nxt_s;
  logic [PC_W-1:0]  pc_inc_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic             halted_r;
  logic             load_s;
  logic             flush_s;
  logic             halt_hit_s;
  logic             valid_d_s;
  logic [INS_W-1:0] ins_d_s;
  logic [PC_W-1:0]  pc_d_s;
  logic [PC_W-1:0]  pc_plus1_d_s;

  assign pc_inc_s   = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  assign halt_hit_s = valid_d_s && (opcode(ins_d_s) == HALT_OP);

  // Next-PC, IF/ID control and state: redirect > stall > halt > normal.
  always_comb begin
    pc_nxt_s    = pc_r;
    state_nxt_s = state_r;
    load_s      = 1'b0;
    flush_s     = 1'b0;
    if (redirect_valid) begin
      pc_nxt_s    = redirect_pc;
      flush_s     = 1'b1;
      state_nxt_s = ST_RUN;
    end else if (stall) begin
      pc_nxt_s = pc_r;
    end else begin
      case (state_r)
        ST_HALT: begin
          flush_s = 1'b1;
        end
        ST_RUN: begin
          pc_nxt_s = pc_inc_s;
          if (halt_hit_s) begin
            // The halt has reached decode: the slot fetched alongside it dies.
            flush_s     = 1'b1;
            state_nxt_s = ST_HALT;
          end else begin
            load_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  // PC and fetch state registers; halted is a registered copy of the state.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      pc_r     <= RST_PC;
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      pc_r     <= pc_nxt_s;
      state_r  <= state_nxt_s;
      halted_r <= (state_nxt_s == ST_HALT);
    end
  end

  if_id_reg #(
    .PC_W  (PC_W),
    .INS_W (INS_W)
  ) u_if_id (
    .clk          (clk),
    .rstd         (rstd),
    .load         (load_s),
    .flush        (flush_s),
    .ins_nxt      (ins_f),
    .pc_nxt       (pc_r),
    .pc_plus1_nxt (pc_inc_s),
    .valid        (valid_d_s),
    .ins          (ins_d_s),
    .pc           (pc_d_s),
    .pc_plus1     (pc_plus1_d_s)
  );

  assign pc_f       = pc_r;
  assign halted     = halted_r;
  assign valid_d    = valid_d_s;
  assign ins_d      = ins_d_s;
  assign pc_d       = pc_d_s;
  assign pc_plus1_d = pc_plus1_d_s;

endmodule
